// File: rtl/sw_pkg.sv
// sw_pkg: shared types and derived constants for the Smith-Waterman
// sequencing controller (sw_ctrl) and its max tracker (sw_max_track).
//   - sw_state_e : controller FSM states
//   - sw_base_e  : 2-bit nucleotide encoding
//   - helpers    : pass count, stream length, index/counter widths
package sw_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PASS_INIT,
    S_STREAM,
    S_WAIT_RES,
    S_DONE
  } sw_state_e;

  typedef enum logic [1:0] {
    BASE_A = 2'd0,
    BASE_C = 2'd1,
    BASE_G = 2'd2,
    BASE_T = 2'd3
  } sw_base_e;

  // Number of row bands needed to cover the query.
  function automatic int pass_num(input int qry_len, input int pe_num);
    return qry_len / pe_num;
  endfunction

  // Streaming cycles per pass: reference bases plus wavefront drain.
  function automatic int stream_len(input int ref_len, input int pe_num);
    return ref_len + pe_num - 1;
  endfunction

  // Bits needed to index 0..n-1 (at least one bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int REF_LEN_DEF    = 64;
  localparam int QRY_LEN_DEF    = 32;
  localparam int PE_NUM_DEF     = 8;
  localparam int PASS_NUM_DEF   = pass_num(QRY_LEN_DEF, PE_NUM_DEF);
  localparam int STREAM_LEN_DEF = stream_len(REF_LEN_DEF, PE_NUM_DEF);

endpackage

// File: rtl/sw_max_track.sv
// sw_max_track: global best-score tracker for sw_ctrl.
//   clk, reset     : clock, asynchronous active-high reset
//   start_i        : clears score/positions at the start of a job
//   take_i         : a pass result is presented this cycle
//   res_max_i      : best score of the pass
//   res_col_i      : 0-based column of that score
//   res_row_i      : 0-based row within the band
//   pass_i         : index of the current pass (band)
//   max_o          : global best score
//   pos_ref_o      : 1-based reference position of best (0 if none)
//   pos_query_o    : 1-based query position of best (0 if none)
// Only a strictly greater score replaces the stored one, so earlier bands
// win ties and an all-zero job leaves the positions at 0.
module sw_max_track #(
  parameter int WIDTH_SCORE     = 8,
  parameter int WIDTH_POS_REF   = 7,
  parameter int WIDTH_POS_QUERY = 6,
  parameter int PE_NUM          = 8,
  parameter int PASS_W          = 2,
  parameter int ROW_W           = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_i,
  input  logic                       take_i,
  input  logic [WIDTH_SCORE-1:0]     res_max_i,
  input  logic [WIDTH_POS_REF-1:0]   res_col_i,
  input  logic [ROW_W-1:0]           res_row_i,
  input  logic [PASS_W-1:0]          pass_i,
  output logic [WIDTH_SCORE-1:0]     max_o,
  output logic [WIDTH_POS_REF-1:0]   pos_ref_o,
  output logic [WIDTH_POS_QUERY-1:0] pos_query_o
);

  logic [WIDTH_SCORE-1:0]     max_q, max_d;
  logic [WIDTH_POS_REF-1:0]   pref_q, pref_d;
  logic [WIDTH_POS_QUERY-1:0] pqry_q, pqry_d;

  always_comb begin
    max_d  = max_q;
    pref_d = pref_q;
    pqry_d = pqry_q;
    if (start_i) begin
      max_d  = '0;
      pref_d = '0;
      pqry_d = '0;
    end else if (take_i && (res_max_i > max_q)) begin
      max_d  = res_max_i;
      pref_d = res_col_i + WIDTH_POS_REF'(1);
      pqry_d = WIDTH_POS_QUERY'(pass_i) * WIDTH_POS_QUERY'(PE_NUM)
             + WIDTH_POS_QUERY'(res_row_i) + WIDTH_POS_QUERY'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_q  <= '0;
      pref_q <= '0;
      pqry_q <= '0;
    end else begin
      max_q  <= max_d;
      pref_q <= pref_d;
      pqry_q <= pqry_d;
    end
  end

  assign max_o       = max_q;
  assign pos_ref_o   = pref_q;
  assign pos_query_o = pqry_q;

endmodule

// File: rtl/sw_ctrl.sv
// sw_ctrl: sequencing controller for the Smith-Waterman accelerator.
// Captures the serial reference/query streams, then drives the PE array
// through QRY_LEN/PE_NUM row-band passes, streaming the reference once per
// pass, and reports the global best score and its 1-based position.
//   clk, reset          : clock, asynchronous active-high reset
//   valid, data_ref,
//   data_query          : input base stream
//   arr_load, arr_query : band load pulse and the band's query bases
//   arr_first           : high for the whole first pass
//   arr_ref_valid,
//   arr_ref             : reference stream into PE 0
//   arr_res_*           : per-pass result from the array
//   finish, max,
//   pos_ref, pos_query  : job completion and global result
// All outputs are registers or decodes of registers.
module sw_ctrl
  import sw_pkg::*;
#(
  parameter int WIDTH_SCORE     = 8,
  parameter int WIDTH_POS_REF   = 7,
  parameter int WIDTH_POS_QUERY = 6,
  parameter int REF_LEN         = 64,
  parameter int QRY_LEN         = 32,
  parameter int PE_NUM          = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid,
  input  logic [1:0]                 data_ref,
  input  logic [1:0]                 data_query,
  output logic                       arr_load,
  output logic [2*PE_NUM-1:0]        arr_query,
  output logic                       arr_first,
  output logic                       arr_ref_valid,
  output logic [1:0]                 arr_ref,
  input  logic                       arr_res_valid,
  input  logic [WIDTH_SCORE-1:0]     arr_res_max,
  input  logic [WIDTH_POS_REF-1:0]   arr_res_col,
  input  logic [$clog2(PE_NUM)-1:0]  arr_res_row,
  output logic                       finish,
  output logic [WIDTH_SCORE-1:0]     max,
  output logic [WIDTH_POS_REF-1:0]   pos_ref,
  output logic [WIDTH_POS_QUERY-1:0] pos_query
);

  localparam int PASS_NUM   = pass_num(QRY_LEN, PE_NUM);
  localparam int STREAM_LEN = stream_len(REF_LEN, PE_NUM);
  localparam int CNT_W      = idx_width((STREAM_LEN > QRY_LEN) ? STREAM_LEN : QRY_LEN);
  localparam int PASS_W     = idx_width(PASS_NUM);
  localparam int RIDX_W     = idx_width(REF_LEN);
  localparam int QIDX_W     = idx_width(QRY_LEN);

  sw_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0]  wr_idx;
  logic              ref_we, qry_we, start, res_take;

  logic [1:0] rbuf_q [REF_LEN];
  logic [1:0] qbuf_q [QRY_LEN];

  // cnt is the store index during IDLE/LOAD and the stream cycle in STREAM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    wr_idx   = cnt_q;
    ref_we   = 1'b0;
    qry_we   = 1'b0;
    start    = 1'b0;
    res_take = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (valid) begin
          ref_we  = 1'b1;
          qry_we  = 1'b1;
          wr_idx  = '0;
          start   = 1'b1;
          cnt_d   = CNT_W'(1);
          pass_d  = '0;
          state_d = (REF_LEN == 1) ? S_PASS_INIT : S_LOAD;
        end
      end
      S_LOAD: begin
        if (valid) begin
          ref_we = 1'b1;
          qry_we = (int'(cnt_q) < QRY_LEN);
          if (int'(cnt_q) == REF_LEN - 1) begin
            cnt_d   = '0;
            state_d = S_PASS_INIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_PASS_INIT: begin
        cnt_d   = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (int'(cnt_q) == STREAM_LEN - 1) begin
          cnt_d   = '0;
          state_d = S_WAIT_RES;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_RES: begin
        if (arr_res_valid) begin
          res_take = 1'b1;
          if (int'(pass_q) == PASS_NUM - 1) begin
            state_d = S_DONE;
          end else begin
            pass_d  = pass_q + PASS_W'(1);
            state_d = S_PASS_INIT;
          end
        end
      end
      S_DONE: begin
        pass_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ref_we) rbuf_q[wr_idx[RIDX_W-1:0]] <= data_ref;
    if (qry_we) qbuf_q[wr_idx[QIDX_W-1:0]] <= data_query;
  end

  assign arr_load      = (state_q == S_PASS_INIT);
  assign finish        = (state_q == S_DONE);
  assign arr_first     = (pass_q == '0) &&
                         ((state_q == S_PASS_INIT) || (state_q == S_STREAM) ||
                          (state_q == S_WAIT_RES));
  assign arr_ref_valid = (state_q == S_STREAM) && (int'(cnt_q) < REF_LEN);
  assign arr_ref       = arr_ref_valid ? rbuf_q[cnt_q[RIDX_W-1:0]] : '0;

  // Band query is only driven while arr_load is high; it reads zero otherwise
  // so the unreset buffer never leaks onto the port.
  always_comb begin
    arr_query = '0;
    if (state_q == S_PASS_INIT) begin
      for (int unsigned i = 0; i < PE_NUM; i++) begin
        arr_query[2*i +: 2] = qbuf_q[QIDX_W'(int'(pass_q) * PE_NUM + int'(i))];
      end
    end
  end

  sw_max_track #(
    .WIDTH_SCORE    (WIDTH_SCORE),
    .WIDTH_POS_REF  (WIDTH_POS_REF),
    .WIDTH_POS_QUERY(WIDTH_POS_QUERY),
    .PE_NUM         (PE_NUM),
    .PASS_W         (PASS_W),
    .ROW_W          ($clog2(PE_NUM))
  ) u_max_track (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start),
    .take_i     (res_take),
    .res_max_i  (arr_res_max),
    .res_col_i  (arr_res_col),
    .res_row_i  (arr_res_row),
    .pass_i     (pass_q),
    .max_o      (max),
    .pos_ref_o  (pos_ref),
    .pos_query_o(pos_query)
  );

endmodule

// File: tb/tb_sw_ctrl.sv
// tb_sw_ctrl: directed bench for sw_ctrl. A job planner lays out per-cycle
// input vectors and the expected output timeline from the behavioural rules
// (pass period, stream order, strict-greater best tracking); one compare
// process checks every output on every cycle, plus literal pins.
module tb_sw_ctrl;

  localparam int REF_LEN  = 64;
  localparam int QRY_LEN  = 32;
  localparam int PE_NUM   = 8;
  localparam int PASS_NUM = QRY_LEN / PE_NUM;
  localparam int N        = 2300;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic [1:0]  data_ref = '0, data_query = '0;
  logic        arr_load, arr_first, arr_ref_valid, finish;
  logic [15:0] arr_query;
  logic [1:0]  arr_ref;
  logic        arr_res_valid = 1'b0;
  logic [7:0]  arr_res_max = '0;
  logic [6:0]  arr_res_col = '0;
  logic [2:0]  arr_res_row = '0;
  logic [7:0]  max;
  logic [6:0]  pos_ref;
  logic [5:0]  pos_query;

  always #5 clk = ~clk;

  sw_ctrl #(.WIDTH_SCORE(8), .WIDTH_POS_REF(7), .WIDTH_POS_QUERY(6),
            .REF_LEN(REF_LEN), .QRY_LEN(QRY_LEN), .PE_NUM(PE_NUM)) dut (
    .clk(clk), .reset(reset), .valid(valid), .data_ref(data_ref),
    .data_query(data_query), .arr_load(arr_load), .arr_query(arr_query),
    .arr_first(arr_first), .arr_ref_valid(arr_ref_valid), .arr_ref(arr_ref),
    .arr_res_valid(arr_res_valid), .arr_res_max(arr_res_max),
    .arr_res_col(arr_res_col), .arr_res_row(arr_res_row), .finish(finish),
    .max(max), .pos_ref(pos_ref), .pos_query(pos_query));

  // Per-cycle stimulus
  bit       in_valid[N], rst_in[N], rv_in[N];
  bit [1:0] in_ref[N], in_qry[N];
  bit [7:0] rmax_in[N];
  bit [6:0] rcol_in[N];
  bit [2:0] rrow_in[N];
  // Per-cycle expectations
  bit        e_load[N], e_rv[N], e_first[N], e_fin[N];
  bit [1:0]  e_ref[N];
  bit [15:0] e_query[N];
  bit [7:0]  e_max[N];
  bit [6:0]  e_pr[N];
  bit [5:0]  e_pq[N];
  bit        clr_at[N], upd_at[N];
  bit [7:0]  u_max[N];
  bit [6:0]  u_pr[N];
  bit [5:0]  u_pq[N];

  int jm[PASS_NUM], jc[PASS_NUM], jr[PASS_NUM];
  int cur = -1;
  int n_chk = 0, n_pass = 0;
  int tA, fA, tB, fB, tC, fC, tD, fD, tE, fE, tF, fF, abortE;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cur, act, req);
  endtask

  task automatic set_res(input int m0, input int m1, input int m2, input int m3,
                         input int c0, input int c1, input int c2, input int c3,
                         input int r0, input int r1, input int r2, input int r3);
    jm[0] = m0; jm[1] = m1; jm[2] = m2; jm[3] = m3;
    jc[0] = c0; jc[1] = c1; jc[2] = c2; jc[3] = c3;
    jr[0] = r0; jr[1] = r1; jr[2] = r2; jr[3] = r3;
  endtask

  // Lays out one job starting with valid in cycle s. The array answers
  // dly cycles after entering WAIT_RES. Nothing is scheduled at/after abort.
  task automatic plan_job(input int s, input int gap_at, input int gap_len,
                          input int dly, input int abort, input bit busy,
                          input bit stray, output int t, output int fin);
    bit [1:0]  rb[REF_LEN];
    bit [1:0]  qb[QRY_LEN];
    bit [15:0] qv;
    int c, n, per, pi, cc, best;
    c = s; n = 0;
    while (n < REF_LEN) begin
      if (n == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          in_valid[c] = 1'b0; in_ref[c] = 2'($urandom); in_qry[c] = 2'($urandom); c++;
        end
      end
      in_valid[c] = 1'b1;
      rb[n] = 2'($urandom_range(0, 3));
      in_ref[c] = rb[n];
      in_qry[c] = 2'($urandom_range(0, 3));
      if (n < QRY_LEN) qb[n] = in_qry[c];
      n++; c++;
    end
    t = c - 1;
    clr_at[s+1] = 1'b1;
    per  = REF_LEN + PE_NUM + 1 + dly;
    best = 0;
    for (int p = 0; p < PASS_NUM; p++) begin
      pi = t + 1 + p * per;
      for (int k = 0; k < per; k++) begin
        cc = pi + k;
        if (cc < abort) begin
          if (busy) begin in_valid[cc] = 1'b1; in_ref[cc] = 2'($urandom); end
          if (p == 0) e_first[cc] = 1'b1;
          if (k == 0) begin
            for (int i = 0; i < PE_NUM; i++) qv[2*i +: 2] = qb[p*PE_NUM + i];
            e_load[cc] = 1'b1; e_query[cc] = qv;
          end
          if (k >= 1 && k <= REF_LEN) begin e_rv[cc] = 1'b1; e_ref[cc] = rb[k-1]; end
          if (stray && p == 0 && k == 10) begin
            rv_in[cc] = 1'b1; rmax_in[cc] = 8'd250; rcol_in[cc] = 7'd3; rrow_in[cc] = 3'd3;
          end
          if (k == per - 1) begin
            rv_in[cc] = 1'b1; rmax_in[cc] = 8'(jm[p]);
            rcol_in[cc] = 7'(jc[p]); rrow_in[cc] = 3'(jr[p]);
            if (jm[p] > best) begin
              best = jm[p];
              upd_at[cc+1] = 1'b1; u_max[cc+1] = 8'(jm[p]);
              u_pr[cc+1] = 7'(jc[p] + 1); u_pq[cc+1] = 6'(p*PE_NUM + jr[p] + 1);
            end
          end
        end
      end
    end
    fin = t + 1 + PASS_NUM * per;
    if (fin < abort) begin
      e_fin[fin] = 1'b1;
      if (busy) in_valid[fin] = 1'b1;
    end
  endtask

  // Single compare process
  always @(negedge clk) begin
    if (cur >= 0 && cur < N) begin
      chk("arr_load",      32'(arr_load),      32'(e_load[cur]));
      chk("arr_query",     32'(arr_query),     32'(e_query[cur]));
      chk("arr_first",     32'(arr_first),     32'(e_first[cur]));
      chk("arr_ref_valid", 32'(arr_ref_valid), 32'(e_rv[cur]));
      chk("arr_ref",       32'(arr_ref),       32'(e_ref[cur]));
      chk("finish",        32'(finish),        32'(e_fin[cur]));
      chk("max",           32'(max),           32'(e_max[cur]));
      chk("pos_ref",       32'(pos_ref),       32'(e_pr[cur]));
      chk("pos_query",     32'(pos_query),     32'(e_pq[cur]));
      // Literal pins
      if (cur == tA + 1 || cur == tA + 74 || cur == tA + 147 || cur == tA + 220)
        chk("A_load_lit", 32'(arr_load), 32'd1);
      if (cur == tA + 293) begin
        chk("A_fin_lit", 32'(finish), 32'd1);
        chk("A_max_lit", 32'(max), 32'd7);
        chk("A_pref_lit", 32'(pos_ref), 32'd21);
        chk("A_pqry_lit", 32'(pos_query), 32'd11);
      end
      if (cur == tB - 66 + 67) chk("B_gap_load_lit", 32'(arr_load), 32'd1);
      if (cur == tB + 293) begin
        chk("B_max_lit", 32'(max), 32'd12);
        chk("B_pref_lit", 32'(pos_ref), 32'd2);
        chk("B_pqry_lit", 32'(pos_query), 32'd32);
      end
      if (cur == tC + 293) begin
        chk("C_fin_lit", 32'(finish), 32'd1);
        chk("C_max_lit", 32'(max), 32'd0);
        chk("C_pref_lit", 32'(pos_ref), 32'd0);
        chk("C_pqry_lit", 32'(pos_query), 32'd0);
      end
      if (cur == tD + 293) chk("D_nofin_lit", 32'(finish), 32'd0);
      if (cur == tD + 313) begin
        chk("D_fin_lit", 32'(finish), 32'd1);
        chk("D_max_lit", 32'(max), 32'd7);
      end
      if (cur == abortE) begin
        chk("E_rst_load_lit", 32'(arr_load | arr_ref_valid | arr_first | finish), 32'd0);
        chk("E_rst_max_lit", 32'(max), 32'd0);
      end
      if (cur == tF + 293) begin
        chk("F_fin_lit", 32'(finish), 32'd1);
        chk("F_max_lit", 32'(max), 32'd1);
        chk("F_pref_lit", 32'(pos_ref), 32'd11);
        chk("F_pqry_lit", 32'(pos_query), 32'd2);
      end
    end
  end

  initial begin
    bit [7:0] cm;
    bit [6:0] cp;
    bit [5:0] cq;
    int dummy;
    for (int c = 0; c < 3; c++) rst_in[c] = 1'b1;

    // A: baseline, tie in pass 2 keeps pass 1
    set_res(5, 7, 7, 3, 10, 20, 30, 40, 1, 2, 3, 4);
    plan_job(15, -1, 0, 0, N, 1'b0, 1'b0, tA, fA);
    // B: 3-cycle valid gap, valid held high while busy, edge column/row
    set_res(9, 2, 9, 12, 0, 63, 5, 1, 0, 7, 3, 7);
    plan_job(fA + 3, 20, 3, 0, N, 1'b1, 1'b0, tB, fB);
    // C: all-zero results after a non-zero job
    set_res(0, 0, 0, 0, 5, 6, 7, 8, 1, 1, 1, 1);
    plan_job(fB + 3, -1, 0, 0, N, 1'b0, 1'b0, tC, fC);
    // D: array answers 5 cycles late; stray result pulse during streaming
    set_res(5, 7, 7, 3, 10, 20, 30, 40, 1, 2, 3, 4);
    plan_job(fC + 3, -1, 0, 5, N, 1'b0, 1'b1, tD, fD);
    // E: reset during pass 2 streaming
    set_res(9, 9, 9, 9, 1, 2, 3, 4, 0, 0, 0, 0);
    abortE = fD + 3 + 63 + 1 + 2 * 73 + 20;
    plan_job(fD + 3, -1, 0, 0, abortE, 1'b0, 1'b0, tE, fE);
    rst_in[abortE] = 1'b1;
    // F: fresh job after abort
    set_res(1, 1, 1, 1, 10, 10, 10, 10, 1, 1, 1, 1);
    plan_job(abortE + 3, -1, 0, 0, N, 1'b0, 1'b0, tF, fF);
    dummy = fE;

    cm = '0; cp = '0; cq = '0;
    for (int c = 0; c < N; c++) begin
      if (clr_at[c]) begin cm = '0; cp = '0; cq = '0; end
      if (upd_at[c]) begin cm = u_max[c]; cp = u_pr[c]; cq = u_pq[c]; end
      if (rst_in[c]) begin cm = '0; cp = '0; cq = '0; end
      e_max[c] = cm; e_pr[c] = cp; e_pq[c] = cq;
    end

    for (int c = 0; c < N; c++) begin
      @(posedge clk);
      cur = c;
      #1;
      reset         = rst_in[c];
      valid         = in_valid[c];
      data_ref      = in_ref[c];
      data_query    = in_qry[c];
      arr_res_valid = rv_in[c];
      arr_res_max   = rmax_in[c];
      arr_res_col   = rcol_in[c];
      arr_res_row   = rrow_in[c];
    end
    @(negedge clk);
    #2;
    cur = N;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
